// File: rtl/rxcommaalign_scheduler.sv
// Round-robin RX comma-alignment sequencer for the PL BASE-X transceiver channels.
// Grants one channel's rxcommaalignen GPI bit at a time and tracks per-channel lock/timeout status.
module rxcommaalign_scheduler #(
  parameter int NUM_CH         = 4,
  parameter int GPI_BASE       = 8,
  parameter int LOCK_CYCLES    = 64,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_enable,
  input  logic [NUM_CH-1:0] i_ch_req,
  input  logic [NUM_CH-1:0] i_rx_byteisaligned,
  input  logic              i_clr_sticky,
  output logic [15:0]       o_gpi_out,
  output logic [NUM_CH-1:0] o_ch_locked,
  output logic [NUM_CH-1:0] o_ch_timeout,
  output logic              o_busy,
  output logic [2:0]        o_active_ch
);
  // state | meaning
  // IDLE  | scheduler disabled, no grant
  // ARB   | searching for the next eligible channel from the rr pointer
  // ALIGN | grant held, waiting for an aligned sample
  // QUAL  | grant held, counting consecutive aligned samples
  typedef enum logic [1:0] {S_IDLE, S_ARB, S_ALIGN, S_QUAL} state_t;

  localparam int             QW      = $clog2(LOCK_CYCLES + 1);
  localparam logic [QW-1:0]  QLAST   = QW'(LOCK_CYCLES - 1);
  localparam logic [15:0]    TLOAD   = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]     CH_LAST = 3'(NUM_CH - 1);

  state_t        r_state, w_state_nxt;
  logic [2:0]    r_rr, r_active;
  logic [15:0]   r_gpi, r_tmr;
  logic          r_busy;
  logic [7:0]    r_locked, r_timeout;
  logic [QW-1:0] r_qcnt;

  logic [7:0]    w_req8, w_al8, w_elig8;
  logic [3:0]    w_idx;
  logic [2:0]    w_grant, w_active_inc;
  logic          w_found, w_held, w_act_req, w_act_al, w_tmo, w_lock, w_abort, w_end;
  logic [2:0]    w_rr_nxt, w_active_nxt;
  logic [15:0]   w_gpi_nxt, w_tmr_nxt;
  logic          w_busy_nxt;
  logic [7:0]    w_locked_nxt, w_timeout_nxt;
  logic [QW-1:0] w_qcnt_nxt;

  // Channel vectors padded to 8 bits so a 3-bit channel index always fits.
  assign w_req8  = 8'(i_ch_req);
  assign w_al8   = 8'(i_rx_byteisaligned);
  assign w_elig8 = w_req8 & ~r_locked;

  assign w_held       = (r_state == S_ALIGN) || (r_state == S_QUAL);
  assign w_act_req    = w_req8[r_active];
  assign w_act_al     = w_al8[r_active];
  assign w_tmo        = (r_tmr == 16'd0);
  assign w_lock       = w_act_al && ((r_state == S_ALIGN) ? (LOCK_CYCLES == 1) : (r_qcnt == QLAST));
  assign w_abort      = ~w_act_req;
  assign w_end        = w_held && i_enable && (w_abort || w_lock || w_tmo);
  assign w_active_inc = (r_active == CH_LAST) ? 3'd0 : r_active + 3'd1;

  always_comb begin
    w_found = 1'b0;
    w_grant = 3'd0;
    w_idx   = 4'd0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_idx = {1'b0, r_rr} + 4'(k);
      if (w_idx >= 4'(NUM_CH)) w_idx = w_idx - 4'(NUM_CH);
      if (!w_found && w_elig8[w_idx[2:0]]) begin
        w_found = 1'b1;
        w_grant = w_idx[2:0];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!i_enable) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  w_state_nxt = S_ARB;
        S_ARB:   if (w_found) w_state_nxt = S_ALIGN;
        S_ALIGN,
        S_QUAL: begin
          if (w_end)          w_state_nxt = S_ARB;
          else if (w_act_al)  w_state_nxt = S_QUAL;
          else                w_state_nxt = S_ALIGN;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Lock loss and sticky clear apply every cycle; lock beats timeout on the same sample.
  always_comb begin
    w_rr_nxt      = r_rr;
    w_active_nxt  = r_active;
    w_gpi_nxt     = r_gpi;
    w_busy_nxt    = r_busy;
    w_tmr_nxt     = r_tmr;
    w_qcnt_nxt    = r_qcnt;
    w_locked_nxt  = r_locked & w_al8;
    w_timeout_nxt = i_clr_sticky ? 8'd0 : r_timeout;
    if (!i_enable) begin
      w_active_nxt = 3'd0;
      w_gpi_nxt    = 16'd0;
      w_busy_nxt   = 1'b0;
      w_qcnt_nxt   = '0;
    end else if (r_state == S_ARB && w_found) begin
      w_active_nxt = w_grant;
      w_gpi_nxt    = 16'd1 << (5'(GPI_BASE) + {2'b00, w_grant});
      w_busy_nxt   = 1'b1;
      w_tmr_nxt    = TLOAD;
      w_qcnt_nxt   = '0;
    end else if (w_held) begin
      if (w_end) begin
        w_active_nxt = 3'd0;
        w_gpi_nxt    = 16'd0;
        w_busy_nxt   = 1'b0;
        w_qcnt_nxt   = '0;
        w_rr_nxt     = w_active_inc;
        if (!w_abort && w_lock)  w_locked_nxt[r_active]  = 1'b1;
        else if (!w_abort)       w_timeout_nxt[r_active] = 1'b1;
      end else begin
        w_tmr_nxt  = r_tmr - 16'd1;
        w_qcnt_nxt = w_act_al ? r_qcnt + QW'(1) : '0;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rr      <= 3'd0;
      r_active  <= 3'd0;
      r_gpi     <= 16'd0;
      r_busy    <= 1'b0;
      r_tmr     <= 16'd0;
      r_qcnt    <= '0;
      r_locked  <= 8'd0;
      r_timeout <= 8'd0;
    end else begin
      r_rr      <= w_rr_nxt;
      r_active  <= w_active_nxt;
      r_gpi     <= w_gpi_nxt;
      r_busy    <= w_busy_nxt;
      r_tmr     <= w_tmr_nxt;
      r_qcnt    <= w_qcnt_nxt;
      r_locked  <= w_locked_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign o_gpi_out    = r_gpi;
  assign o_ch_locked  = r_locked[NUM_CH-1:0];
  assign o_ch_timeout = r_timeout[NUM_CH-1:0];
  assign o_busy       = r_busy;
  assign o_active_ch  = r_active;

endmodule

// File: tb/tb_rxcommaalign_scheduler.sv
// Bench for rxcommaalign_scheduler: directed vector table, hand-written corner sequences,
// then random stimulus against a grant-level reference model.
module tb_rxcommaalign_scheduler;
  localparam int NCH = 4, BASE = 8, LOCK = 64, TMO = 4096;

  logic           clk = 1'b0;
  logic           rst, enable, clr_sticky;
  logic [NCH-1:0] ch_req, aligned;
  logic [15:0]    gpi;
  logic [NCH-1:0] locked, timeout;
  logic           busy;
  logic [2:0]     active;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rxcommaalign_scheduler #(
    .NUM_CH(NCH), .GPI_BASE(BASE), .LOCK_CYCLES(LOCK), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_ch_req(ch_req),
    .i_rx_byteisaligned(aligned), .i_clr_sticky(clr_sticky),
    .o_gpi_out(gpi), .o_ch_locked(locked), .o_ch_timeout(timeout),
    .o_busy(busy), .o_active_ch(active)
  );

  typedef struct {
    int         ch;
    int         delay;
    int         exp_high;
    logic [3:0] exp_locked;
    logic [3:0] exp_tmo;
  } vec_t;

  // Reference model: grant-level view of the scheduler.
  int         m_mode;  // 0 = off, 1 = looking for a channel, 2 = holding a grant
  int         m_ch, m_age, m_run, m_rr;
  logic [3:0] m_locked, m_tmo;

  task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act_v, exp_v, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; ch_req = '0; aligned = '0; clr_sticky = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  function automatic logic [15:0] bitw(input int ch);
    return 16'd1 << (BASE + ch);
  endfunction

  task automatic wait_gpi(input string name, input logic [15:0] want, input int limit);
    int n = 0;
    while (gpi !== want && n < limit) begin
      tick();
      n++;
    end
    check(name, gpi, want);
  endtask

  // Called on the sample where the grant bit first shows; drives aligned[ch] high from
  // cycle 'delay' onward (never if negative) except in cycle 'gap', and counts high cycles.
  task automatic run_grant(input int ch, input int delay, input int gap,
                           output int high, output bit clean);
    high = 0;
    clean = 1'b1;
    while (gpi !== 16'd0 && high < TMO + 10) begin
      if (gpi !== bitw(ch)) clean = 1'b0;
      aligned[ch] = (delay >= 0 && high >= delay && high != gap);
      tick();
      high++;
    end
  endtask

  task automatic model_step(input logic [3:0] req, input logic [3:0] al,
                            input logic en, input logic clr);
    logic [3:0] nl, nt;
    bit         done, found;
    int         g;
    nl = m_locked & al;
    nt = clr ? 4'd0 : m_tmo;
    done = 1'b0;
    if (!en) begin
      m_mode = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      found = 1'b0;
      for (int k = 0; k < NCH; k++) begin
        g = (m_rr + k) % NCH;
        if (!found && req[g] && !m_locked[g]) begin
          found = 1'b1;
          m_ch = g;
        end
      end
      if (found) begin
        m_mode = 2;
        m_age = 0;
        m_run = 0;
      end
    end else begin
      if (!req[m_ch]) begin
        done = 1'b1;
      end else begin
        m_run = al[m_ch] ? m_run + 1 : 0;
        if (m_run == LOCK) begin
          nl[m_ch] = 1'b1;
          done = 1'b1;
        end else if (m_age == TMO - 1) begin
          nt[m_ch] = 1'b1;
          done = 1'b1;
        end else begin
          m_age++;
        end
      end
      if (done) begin
        m_mode = 1;
        m_rr = (m_ch + 1) % NCH;
      end
    end
    m_locked = nl;
    m_tmo = nt;
  endtask

  function automatic logic [31:0] model_out();
    logic [15:0] eg;
    logic [2:0]  ea;
    eg = (m_mode == 2) ? bitw(m_ch) : 16'd0;
    ea = (m_mode == 2) ? 3'(m_ch) : 3'd0;
    return {4'd0, eg, m_locked, m_tmo, (m_mode == 2), ea};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[4];
    int   high;
    bit   clean;

    vt[0] = '{0, 10, 74, 4'b0001, 4'b0000};
    vt[1] = '{3, 0, 64, 4'b1000, 4'b0000};
    vt[2] = '{2, 37, 101, 4'b0100, 4'b0000};
    vt[3] = '{1, -1, TMO, 4'b0000, 4'b0010};

    rst = 1'b0; enable = 1'b0; ch_req = '0; aligned = '0; clr_sticky = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("reset_async_outputs", {gpi, locked, timeout, busy, active}, 32'd0);
    tick();
    rst = 1'b0;

    // Single-channel grants: lock after a delay, or time out.
    foreach (vt[v]) begin
      do_reset();
      enable = 1'b1;
      ch_req = 4'(1 << vt[v].ch);
      tick();
      check("arb_no_early_grant", gpi, 16'd0);
      tick();
      check("grant_latency", gpi, bitw(vt[v].ch));
      check("grant_busy_active", {busy, active}, {1'b1, 3'(vt[v].ch)});
      run_grant(vt[v].ch, vt[v].delay, -1, high, clean);
      check("vec_high_cycles", high, vt[v].exp_high);
      check("vec_onehot", clean, 1'b1);
      check("vec_busy_falls", {busy, active}, 4'd0);
      check("vec_locked", locked, vt[v].exp_locked);
      check("vec_timeout", timeout, vt[v].exp_tmo);
    end
    tick();
    check("timeout_regrant", gpi, bitw(1));
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    check("clr_sticky", timeout, 4'd0);

    // All channels requesting: strict round-robin order, then lock loss re-arms ch2.
    do_reset();
    enable = 1'b1;
    ch_req = 4'b1111;
    for (int c = 0; c < NCH; c++) begin
      wait_gpi("rr_order", bitw(c), 20);
      run_grant(c, 5, -1, high, clean);
      check("rr_high_cycles", high, 69);
      check("rr_onehot", clean, 1'b1);
    end
    check("rr_all_locked", locked, 4'b1111);
    aligned[2] = 1'b0;
    tick();
    check("lock_loss", {gpi, locked}, {16'd0, 4'b1011});
    tick();
    check("relock_grant", gpi, bitw(2));

    // One-cycle alignment drop at qcnt=30 restarts the qualification run.
    do_reset();
    enable = 1'b1;
    ch_req = 4'b0001;
    wait_gpi("glitch_grant", bitw(0), 5);
    run_grant(0, 0, 30, high, clean);
    check("glitch_high_cycles", high, 95);
    check("glitch_onehot", clean, 1'b1);
    check("glitch_locked", locked, 4'b0001);

    // Asynchronous reset while ch3 is in ALIGN.
    do_reset();
    enable = 1'b1;
    ch_req = 4'b1001;
    aligned = 4'b0001;
    wait_gpi("ar_grant0", bitw(0), 5);
    run_grant(0, 0, -1, high, clean);
    wait_gpi("ar_grant3", bitw(3), 5);
    check("ar_pre_locked", locked, 4'b0001);
    repeat (3) tick();
    check("ar_busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("ar_async_clear", {gpi, locked, busy, active}, 24'd0);
    tick();
    rst = 1'b0;

    // Enable drop during QUAL, then request withdrawal during ALIGN.
    do_reset();
    enable = 1'b1;
    ch_req = 4'b0011;
    aligned = 4'b0011;
    wait_gpi("en_grant0", bitw(0), 5);
    run_grant(0, 0, -1, high, clean);
    wait_gpi("en_grant1", bitw(1), 5);
    repeat (10) tick();
    check("en_busy_qual", busy, 1'b1);
    enable = 1'b0;
    tick();
    check("en_low_clears", {gpi, busy, active, locked}, {16'd0, 1'b0, 3'd0, 4'b0001});
    tick();
    check("en_low_idle", gpi, 16'd0);
    enable = 1'b1;
    tick();
    check("en_arb_cycle", gpi, 16'd0);
    tick();
    check("en_regrant", gpi, bitw(1));
    aligned[1] = 1'b0;
    repeat (5) tick();
    ch_req[1] = 1'b0;
    tick();
    check("abort_clears", {gpi, busy, timeout, locked}, {16'd0, 1'b0, 4'd0, 4'b0001});

    // Random stimulus against the reference model.
    do_reset();
    m_mode = 0; m_ch = 0; m_age = 0; m_run = 0; m_rr = 0; m_locked = '0; m_tmo = '0;
    check("model_reset", {4'd0, gpi, locked, timeout, busy, active}, model_out());
    aligned = 4'($urandom_range(0, 15));
    ch_req  = 4'($urandom_range(0, 15));
    for (int c = 0; c < 20000; c++) begin
      for (int i = 0; i < NCH; i++) begin
        if ($urandom_range(0, (i == 3) ? 2999 : 149) == 0) aligned[i] = ~aligned[i];
        if ($urandom_range(0, 599) == 0) ch_req[i] = ~ch_req[i];
      end
      enable     = ($urandom_range(0, 999) != 0);
      clr_sticky = ($urandom_range(0, 499) == 0);
      tick();
      model_step(ch_req, aligned, enable, clr_sticky);
      check("model_cycle", {4'd0, gpi, locked, timeout, busy, active}, model_out());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rxcommaalign_scheduler.md
Name: rxcommaalign_scheduler

Overview:
- Sequences per-channel RX comma alignment for the PL BASE-X transceiver channels.
- Grants one channel at a time, round-robin, and drives that channel's rxcommaalignen bit at position GPI_BASE+ch of the 16-bit GPI word.
- Holds the bit until byte alignment has been stable for LOCK_CYCLES cycles, or until a timeout expires.
- Tracks per-channel lock status and re-arms a channel when it loses alignment.

Parameters:
- NUM_CH, 4: number of channels, 1..8. GPI_BASE+NUM_CH must be ≤16.
- GPI_BASE, 8: GPI bit index of channel 0's align enable.
- LOCK_CYCLES, 64: consecutive aligned samples required to declare lock, ≥1.
- TIMEOUT_CYCLES, 4096: maximum cycles a grant is held, >LOCK_CYCLES, ≤65535.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  scheduler run. Low forces IDLE.
- ch_req  in  NUM_CH  per-channel request to be aligned (level).
- rx_byteisaligned  in  NUM_CH  per-channel aligned status, already synchronized to clk.
- clr_sticky  in  1  one-cycle pulse that clears all ch_timeout bits.
- gpi_out  out  16  GPI word; only bit GPI_BASE+active_ch can be 1.
- ch_locked  out  NUM_CH  per-channel lock status.
- ch_timeout  out  NUM_CH  sticky timeout flags.
- busy  out  1  high in ALIGN or QUAL.
- active_ch  out  3  index of the granted channel; 0 when not busy.

Behaviour:
- Reset (async assert): all outputs are 0, state=IDLE, rr pointer=0, all counters=0.
- All outputs are registered.
- Eligibility: channel i is eligible when ch_req[i]=1 and ch_locked[i]=0.
- States and transitions:
  - IDLE: when enable=1, go to ARB next cycle.
  - ARB: if any channel is eligible, grant the first eligible channel at or after the rr pointer (wrapping modulo NUM_CH). On that edge: active_ch=grant, gpi bit set, tcnt=0, go to ALIGN.
    - gpi bit rises exactly 1 cycle after ARB is entered with an eligible channel present.
    - If no channel is eligible, stay in ARB.
  - ALIGN: tcnt increments each cycle. If rx_byteisaligned[active]=1, go to QUAL with qcnt=1.
  - QUAL: tcnt increments each cycle.
    - aligned=1: qcnt++.
    - aligned=0: back to ALIGN, qcnt=0, tcnt keeps running.
    - Lock when the LOCK_CYCLES-th consecutive high sample is seen (counting the ALIGN detection sample). On that edge: ch_locked[active]=1, gpi word=0, busy=0, rr pointer=active+1 (wrapping), go to ARB.
    - LOCK_CYCLES=1: lock directly from the ALIGN detection sample.
- Timeout: when tcnt reaches TIMEOUT_CYCLES-1 in ALIGN or QUAL, set ch_timeout[active], clear gpi, advance rr pointer, go to ARB.
  - The gpi bit is therefore high for exactly TIMEOUT_CYCLES cycles.
  - The channel stays eligible and is retried on a later round.
- Lock and timeout in the same cycle: lock wins; ch_timeout is not set.
- Request withdrawn: ch_req[active]=0 while busy aborts the grant. gpi clears on the next edge, rr pointer advances, go to ARB. No flags change.
- Lock loss: for any locked channel i (granted or not), rx_byteisaligned[i]=0 clears ch_locked[i] on the next edge. The channel becomes eligible again.
  - A locked channel whose ch_req drops keeps ch_locked until alignment is lost.
- enable low: from any state go to IDLE on the next edge. gpi=0, busy=0, active_ch=0. ch_locked and ch_timeout are retained.
- clr_sticky: clears all ch_timeout bits. A timeout set in the same cycle wins.
- Counter widths: tcnt is 16 bits; qcnt is wide enough for LOCK_CYCLES. Neither counter wraps.
- Fairness: each eligible channel is granted within NUM_CH-1 grants of any other channel.

Test Plan:
1. NUM_CH=4. Reset, then enable=1 and ch_req=4'b0001; drive aligned[0] high 10 cycles after gpi[8] rises → gpi[8] stays high 10+64 cycles then falls; ch_locked=4'b0001; busy falls on the same edge as gpi[8].
2. ch_req=4'b1111, each channel aligns after 5 cycles → gpi bits 8, 9, 10, 11 rise in that order, never two at once; ch_locked=4'b1111. Then drop aligned[2] → ch_locked[2] clears next cycle and gpi[10] re-asserts after ARB.
3. ch_req=4'b0010, aligned[1] held low → gpi[9] high exactly 4096 cycles; ch_timeout=4'b0010; channel regranted; a clr_sticky pulse clears ch_timeout.
4. During QUAL of ch0, drop aligned[0] for 1 cycle at qcnt=30 → returns to ALIGN; lock needs a fresh 64-sample run; gpi[8] held throughout.
5. Assert rst mid-ALIGN of ch3 → gpi_out=0, ch_locked=0 and busy=0 immediately, without waiting for a clock edge.
6. enable low during QUAL → gpi=0 next edge, state IDLE, ch_locked unchanged. ch_req[active] low mid-ALIGN → abort with no ch_timeout set.
